// File: rtl/seg_value_formatter.sv
// Formats a 32-bit value as eight 7-segment glyphs (hex or decimal).
// Decimal uses a sequential shift-add-3 binary-to-BCD converter.
module seg_value_formatter #(
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        mode,
  input  logic [7:0]  dp,
  output logic        busy,
  output logic        done,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] bin;
  logic [31:0] bcd;
  logic [31:0] adj;
  logic [31:0] src;
  logic        mode_q;
  logic        ovf;
  logic [7:0]  dp_q;
  logic [7:0]  nxt [8];
  logic [3:0]  dig;
  logic [3:0]  nib;
  logic [7:0]  g;
  logic        seen;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] r;
    unique case (d)
      4'h0: r = 8'hC0;
      4'h1: r = 8'hF9;
      4'h2: r = 8'hA4;
      4'h3: r = 8'hB0;
      4'h4: r = 8'h99;
      4'h5: r = 8'h92;
      4'h6: r = 8'h82;
      4'h7: r = 8'hF8;
      4'h8: r = 8'h80;
      4'h9: r = 8'h90;
      4'hA: r = 8'h88;
      4'hB: r = 8'h83;
      4'hC: r = 8'hC6;
      4'hD: r = 8'hA1;
      4'hE: r = 8'h86;
      4'hF: r = 8'h8E;
    endcase
    return r;
  endfunction

  always_comb begin
    adj = bcd;
    nib = 4'h0;
    for (int k = 0; k < 8; k++) begin
      nib = bcd[4*k +: 4];
      adj[4*k +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  // Scan from the top digit down; "seen" flips at the first non-zero digit.
  always_comb begin
    src  = mode_q ? bcd : bin;
    seen = 1'b0;
    dig  = 4'h0;
    g    = 8'hFF;
    for (int i = 0; i < 8; i++) nxt[i] = 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      dig = src[4*i +: 4];
      if (dig != 4'h0 || i == 0) seen = 1'b1;
      if (ovf)
        g = 8'hBF;
      else if (LZ_BLANK != 0 && !seen)
        g = 8'hFF;
      else
        g = glyph(dig);
      if (!ovf && dp_q[i]) g[7] = 1'b0;
      nxt[i] = g;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      bin    <= 32'd0;
      bcd    <= 32'd0;
      mode_q <= 1'b0;
      ovf    <= 1'b0;
      dp_q   <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      seg0   <= 8'hFF;
      seg1   <= 8'hFF;
      seg2   <= 8'hFF;
      seg3   <= 8'hFF;
      seg4   <= 8'hFF;
      seg5   <= 8'hFF;
      seg6   <= 8'hFF;
      seg7   <= 8'hFF;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            bin    <= value;
            bcd    <= 32'd0;
            mode_q <= mode;
            dp_q   <= dp;
            cnt    <= 5'd0;
            busy   <= 1'b1;
            ovf    <= mode && (value > 32'd99_999_999);
            if (mode && value <= 32'd99_999_999)
              state <= SHIFT;
            else
              state <= ENCODE;
          end
        end
        SHIFT: begin
          bcd <= {adj[30:0], bin[31]};
          bin <= {bin[30:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= ENCODE;
        end
        ENCODE: begin
          seg0  <= nxt[0];
          seg1  <= nxt[1];
          seg2  <= nxt[2];
          seg3  <= nxt[3];
          seg4  <= nxt[4];
          seg5  <= nxt[5];
          seg6  <= nxt[6];
          seg7  <= nxt[7];
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= 5'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_value_formatter.sv
// Directed vector bench for seg_value_formatter.
// Table of hand-computed glyph sets plus abort/ignore sequences.
module tb_seg_value_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] value;
  logic        mode;
  logic [7:0]  dp;
  logic        busy;
  logic        done;
  logic [7:0]  seg0, seg1, seg2, seg3;
  logic [7:0]  seg4, seg5, seg6, seg7;

  int total = 0;
  int bad   = 0;

  seg_value_formatter #(.LZ_BLANK(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .value(value),
    .mode (mode),
    .dp   (dp),
    .busy (busy),
    .done (done),
    .seg0 (seg0),
    .seg1 (seg1),
    .seg2 (seg2),
    .seg3 (seg3),
    .seg4 (seg4),
    .seg5 (seg5),
    .seg6 (seg6),
    .seg7 (seg7)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] v;
    logic        m;
    logic [7:0]  d;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [63:0] segs();
    return {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] v,
                     input logic m, input logic [7:0] d,
                     input logic [63:0] exp, input int explat,
                     input int poke);
    int   lat;
    logic got;
    logic busy_bad;
    @(negedge clk);
    value = v;
    mode  = m;
    dp    = d;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk({nm, "_busy_rise"}, 64'(busy), 64'd1);
    lat      = 0;
    got      = 1'b0;
    busy_bad = 1'b0;
    while (lat < 40 && !got) begin
      if (lat == poke) begin
        load  = 1'b1;
        value = 32'h5;
        mode  = 1'b0;
        dp    = 8'h00;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      lat++;
      if (done) got = 1'b1;
      else if (!busy) busy_bad = 1'b1;
    end
    chk({nm, "_latency"}, got ? 64'(lat) : 64'd999, 64'(explat));
    chk({nm, "_busy_hold"}, 64'(busy_bad), 64'd0);
    chk({nm, "_busy_fall"}, 64'(busy), 64'd0);
    chk({nm, "_segs"}, segs(), exp);
  endtask

  initial begin
    vecs[0] = '{"hex1234", 32'h1234ABCD, 1'b0, 8'h00,
                64'hF9A4B0998883C6A1, 1};
    vecs[1] = '{"dec1234", 32'd12_345_678, 1'b1, 8'h00,
                64'hF9A4B0999282F880, 33};
    vecs[2] = '{"dec42dp", 32'd42, 1'b1, 8'h04,
                64'hFFFFFFFFFF7F99A4, 33};
    vecs[3] = '{"hexzero", 32'd0, 1'b0, 8'h00,
                64'hFFFFFFFFFFFFFFC0, 1};
    vecs[4] = '{"ovf", 32'd100_000_000, 1'b1, 8'hFF,
                64'hBFBFBFBFBFBFBFBF, 1};
    vecs[5] = '{"decmax", 32'd99_999_999, 1'b1, 8'h00,
                64'h9090909090909090, 33};
    vecs[6] = '{"hexmid", 32'h00F00000, 1'b0, 8'h01,
                64'hFFFF8EC0C0C0C040, 1};
    vecs[7] = '{"hexff", 32'hFFFFFFFF, 1'b0, 8'h80,
                64'h0E8E8E8E8E8E8E8E, 1};
    vecs[8] = '{"dec0dp", 32'd0, 1'b1, 8'h02,
                64'hFFFFFFFFFFFF7FC0, 33};

    rst   = 1'b0;
    load  = 1'b0;
    value = 32'd0;
    mode  = 1'b0;
    dp    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_segs", segs(), {8{8'hFF}});
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i].nm, vecs[i].v, vecs[i].m, vecs[i].d,
          vecs[i].exp, vecs[i].lat, -1);
      @(posedge clk);
      #1;
      chk({vecs[i].nm, "_done_pulse"}, 64'(done), 64'd0);
    end

    // load pulsed mid-SHIFT must be dropped
    run("ignore", 32'd12_345_678, 1'b1, 8'h00,
        64'hF9A4B0999282F880, 33, 5);

    // load accepted in the same cycle done is high
    run("b2b_a", 32'h0000ABCD, 1'b0, 8'h00,
        64'hFFFFFFFF8883C6A1, 1, -1);
    chk("b2b_done_hi", 64'(done), 64'd1);
    run("b2b_b", 32'd42, 1'b1, 8'h00,
        64'hFFFFFFFFFFFF99A4, 33, -1);

    // reset mid-SHIFT aborts without done
    @(negedge clk);
    value = 32'd12_345_678;
    mode  = 1'b1;
    dp    = 8'h00;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_segs", segs(), {8{8'hFF}});
    chk("abort_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done || busy) seen++;
      end
      chk("abort_quiet", 64'(seen), 64'd0);
    end

    run("dec7", 32'd7, 1'b1, 8'h00,
        64'hFFFFFFFFFFFFFFF8, 33, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
